// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO write-port bundle between requester logic and fifo_wr_arbiter.
// master = requester/FIFO side, slave = arbiter.
interface fifo_wr_arbiter_if #(
   parameter int DSIZE = 8,
   parameter int NREQ  = 4
);
   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*DSIZE-1:0] req_data;
   logic [NREQ-1:0]       req_last;
   logic [NREQ-1:0]       req_ready;
   logic                  wfull;
   logic [DSIZE-1:0]      wdata;
   logic                  winc;
   logic [GW-1:0]         gnt_id;
   logic                  busy;

   modport master (output req_valid, req_data, req_last, wfull,
                   input  req_ready, wdata, winc, gnt_id, busy);
   modport slave  (input  req_valid, req_data, req_last, wfull,
                   output req_ready, wdata, winc, gnt_id, busy);
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters, bounded bursts.
// Define FIFO_WR_ARB_PKT_LOCK_EN to hold each grant until the packet's last word.
module fifo_wr_arbiter #(
   parameter int DSIZE    = 8,
   parameter int NREQ     = 4,
   parameter int MAXBURST = 4
) (
   input logic              clk,
   input logic              rst,
   fifo_wr_arbiter_if.slave bus
);
   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(MAXBURST + 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

   state_t           state_r;
   state_t           state_nx_s;
   logic [GW-1:0]    gnt_id_r;
   logic [GW-1:0]    last_gnt_r;
   logic [GW-1:0]    pick_id_s;
   logic [GW-1:0]    scan_s;
   logic             pick_found_s;
   logic [CW-1:0]    burst_cnt_r;
   logic [DSIZE-1:0] wdata_r;
   logic [DSIZE-1:0] data_g_s;
   logic [NREQ-1:0]  ready_s;
   logic             winc_s;
   logic             release_s;
   logic             cnt_hit_s;

   // Round-robin pick: first valid requester after the last grant, wrapping modulo NREQ.
   always_comb begin
      pick_found_s = 1'b0;
      pick_id_s    = '0;
      scan_s       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         scan_s = GW'((int'(last_gnt_r) + k) % NREQ);
         if (!pick_found_s && bus.req_valid[scan_s]) begin
            pick_found_s = 1'b1;
            pick_id_s    = scan_s;
         end else begin
            pick_found_s = pick_found_s;
         end
      end
   end

   // Data of the granted requester; falls back to the last pushed word.
   always_comb begin
      data_g_s = wdata_r;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_id_r == GW'(i)) begin
            data_g_s = bus.req_data[i*DSIZE +: DSIZE];
         end else begin
            data_g_s = data_g_s;
         end
      end
   end

   assign cnt_hit_s = ((int'(burst_cnt_r) + 1) == MAXBURST);

   // Next-state logic and the write-port handshake.
   always_comb begin
      state_nx_s = state_r;
      ready_s    = '0;
      winc_s     = 1'b0;
      release_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (pick_found_s) state_nx_s = ST_BURST;
            else              state_nx_s = ST_IDLE;
         end
         ST_BURST: begin
            // A full FIFO stalls the grant; it neither transfers nor releases.
            ready_s[gnt_id_r] = ~bus.wfull;
            winc_s            = bus.req_valid[gnt_id_r] & ~bus.wfull;
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
            release_s = winc_s & bus.req_last[gnt_id_r];
`else
            release_s = (winc_s & (bus.req_last[gnt_id_r] | cnt_hit_s))
                      | ~bus.req_valid[gnt_id_r];
`endif
            if (release_s) state_nx_s = ST_IDLE;
            else           state_nx_s = ST_BURST;
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_nx_s;
   end

   // Grant bookkeeping, burst counter and held write data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_id_r    <= '0;
         last_gnt_r  <= GW'(NREQ - 1);
         burst_cnt_r <= '0;
         wdata_r     <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               burst_cnt_r <= '0;
               if (pick_found_s) begin
                  gnt_id_r   <= pick_id_s;
                  last_gnt_r <= pick_id_s;
               end
            end
            ST_BURST: begin
               if (winc_s) begin
                  wdata_r <= data_g_s;
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
                  if (burst_cnt_r != {CW{1'b1}}) burst_cnt_r <= burst_cnt_r + CNT_ONE;
`else
                  burst_cnt_r <= burst_cnt_r + CNT_ONE;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready = rst ? '0 : ready_s;
   assign bus.winc      = winc_s & ~rst;
   assign bus.wdata     = (state_r == ST_BURST) ? data_g_s : wdata_r;
   assign bus.gnt_id    = gnt_id_r;
   assign bus.busy      = (state_r == ST_BURST);
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the write port of the dual-clock FIFO between NREQ requesters in the write clock domain.
- Grants one requester at a time for a bounded burst and honours the FIFO full flag, so the FIFO never sees a push while full.
- Sits between requester logic and the FIFO's wdata/winc/wfull pins.

Parameters:
- DSIZE, 8, data word width (matches the FIFO data width).
- NREQ, 4, number of requesters (2..16).
- MAXBURST, 4, maximum words per grant before re-arbitration (>=1).

Ports:
- clk  in  1  write-side clock (FIFO write clock)
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester word valid
- req_data  in  NREQ*DSIZE  per-requester data; requester i occupies bits [i*DSIZE +: DSIZE]
- req_last  in  NREQ  per-requester last word of packet
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- wfull  in  1  FIFO full flag
- wdata  out  DSIZE  FIFO write data
- winc  out  1  FIFO write enable
- gnt_id  out  $clog2(NREQ)  currently/last granted requester
- busy  out  1  high while in BURST

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous, active-high.
- Reset values: state=IDLE, last_gnt=NREQ-1 (requester 0 wins first), burst_cnt=0, gnt_id=0, busy=0. req_ready=0 and winc=0 combinationally while rst is high or in IDLE.
- FSM states: IDLE, BURST.
- IDLE:
  - If any req_valid is high, select the first requester with valid high, scanning from last_gnt+1 upward with wrap modulo NREQ.
  - Register gnt_id, set last_gnt to the selected requester, clear burst_cnt, then go to BURST.
  - Arbitration latency is one cycle: no transfer occurs in IDLE.
- BURST, combinational outputs with g=gnt_id:
  - req_ready[g] = !wfull; all other ready bits are 0.
  - winc = req_valid[g] & !wfull.
  - wdata = req_data[g] when granted; hold the previous value otherwise (no X on wdata).
- Transfer:
  - A transfer is winc=1 on a clk edge; burst_cnt increments on each transfer.
  - burst_cnt width is $clog2(MAXBURST+1); it never exceeds MAXBURST.
- BURST to IDLE on the edge where any of these holds:
  - a transfer with req_last[g]=1;
  - a transfer with burst_cnt+1 == MAXBURST;
  - req_valid[g]=0, i.e. a gap. With wfull=1 and valid high, the grant is held.
- Back-to-back bursts: every burst is followed by at least one IDLE cycle. Round-robin guarantees each active requester is served within NREQ grants.
- wfull boundary: winc is never asserted while wfull=1. A stall does not count toward MAXBURST and does not release the grant.
- Simultaneous events: last and MAXBURST on the same transfer give a single release. A requester dropping valid on the same cycle it wins in IDLE still enters BURST, then releases on the gap.
- Reset mid-burst: immediate return to IDLE. The in-flight word is not pushed unless its edge precedes rst assertion.
- busy = (state==BURST).

Optional Feature:
- Macro: FIFO_WR_ARB_PKT_LOCK_EN.
- Defined:
  - The grant is held until a transfer with req_last[g]=1. MAXBURST and valid gaps do not release it, so packets are never interleaved in the FIFO.
  - burst_cnt saturates at its maximum value rather than wrapping.
- Undefined: release rules exactly as in BURST above. Packets longer than MAXBURST may interleave with other requesters.

Test Plan:
- Reset, then req_valid=4'b0001 with 3 words, last on the 3rd, wfull=0 -> gnt_id=0; winc high 3 consecutive cycles after 1 arbitration cycle; wdata matches; busy drops after the 3rd.
- All four requesters continuously valid, 1-word packets -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
- Requester 2 sends an 8-word packet, MAXBURST=4, requester 1 also valid, macro undefined -> 4 words from 2, then 1 packet from 1, then the remaining 4 from 2. Macro defined -> all 8 words from 2 first.
- wfull forced high for 5 cycles mid-burst -> winc=0 and req_ready=0 during the stall, no grant change, burst_cnt frozen; transfers resume when wfull=0.
- Requester 3 deasserts valid after 2 words without last (macro undefined) -> release to IDLE; requester 0 is granted next if valid.
- rst pulsed asynchronously mid-burst -> req_ready=0 and winc=0 immediately; after release, requester 0 has priority again.
